// File: rtl/updown_counter_param.sv
// Parametrised up/down event counter: programmable limits, saturate/wrap,
// variable step, synchronous load, limit pulse and sticky limit flags.
module updown_counter_param #(
    parameter int                WIDTH     = 8,
    parameter int                STEP_W    = 4,
    parameter int                EDGE_MODE = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              wrap,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              clr_sticky,
    output logic [WIDTH-1:0]  out,
    output logic              at_max,
    output logic              at_min,
    output logic              cfg_err,
    output logic              limit_pulse,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             up_q, down_q;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             up_ev, dn_ev;
    logic             ovf_set, unf_set;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   floor_dn;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    assign cfg_err = (min_val > max_val);

    always_comb begin
        up_ev    = (EDGE_MODE != 0) ? (up & ~up_q) : up;
        dn_ev    = (EDGE_MODE != 0) ? (down & ~down_q) : down;
        // One extra bit so sums past the top of the range are not lost
        sum_up   = {1'b0, out_q} + (WIDTH+1)'(step);
        floor_dn = {1'b0, min_val} + (WIDTH+1)'(step);
        out_d    = out_q;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (!cfg_err) begin
            if (load) begin
                out_d = clamp(load_val, min_val, max_val);
            end else if (enable) begin
                if ((out_q < min_val) || (out_q > max_val)) begin
                    out_d = clamp(out_q, min_val, max_val);
                end else if ((up_ev ^ dn_ev) && (step != '0)) begin
                    if (up_ev) begin
                        if (sum_up <= {1'b0, max_val}) begin
                            out_d = sum_up[WIDTH-1:0];
                        end else begin
                            out_d   = wrap ? min_val : max_val;
                            ovf_set = 1'b1;
                        end
                    end else begin
                        if ({1'b0, out_q} >= floor_dn) begin
                            out_d = out_q - WIDTH'(step);
                        end else begin
                            out_d   = wrap ? max_val : min_val;
                            unf_set = 1'b1;
                        end
                    end
                end
            end
        end
        pulse_d = ovf_set | unf_set;
        // A new limit event outranks a same-cycle clear
        ovf_d   = ovf_set | (ovf_q & ~clr_sticky);
        unf_d   = unf_set | (unf_q & ~clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= RESET_VAL;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            up_q    <= up;
            down_q  <= down;
        end
    end

    assign out         = out_q;
    assign at_max      = (out_q == max_val);
    assign at_min      = (out_q == min_val);
    assign limit_pulse = pulse_q;
    assign ovf_sticky  = ovf_q;
    assign unf_sticky  = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a level-mode and an edge-mode instance share
// stimulus; a cycle-level reference model plus directed tables check both.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset, enable, up, down, wrap, load, clr;
    logic [3:0] step;
    logic [7:0] load_val, min_val, max_val;

    logic [7:0] out0, out1;
    logic       at_max0, at_min0, cfg_err0, pl0, ov0, un0;
    logic       at_max1, at_min1, cfg_err1, pl1, ov1, un1;

    int checks = 0;
    int errors = 0;

    int m_out[2];
    bit m_pl[2], m_ov[2], m_un[2], m_uq[2], m_dq[2];
    int rv[2] = '{0, 200};

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .STEP_W(4), .EDGE_MODE(0), .RESET_VAL(8'd0)) u_lvl (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .down(down), .step(step),
        .wrap(wrap), .load(load), .load_val(load_val), .min_val(min_val), .max_val(max_val),
        .clr_sticky(clr), .out(out0), .at_max(at_max0), .at_min(at_min0), .cfg_err(cfg_err0),
        .limit_pulse(pl0), .ovf_sticky(ov0), .unf_sticky(un0));

    updown_counter_param #(.WIDTH(8), .STEP_W(4), .EDGE_MODE(1), .RESET_VAL(8'd200)) u_edge (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .down(down), .step(step),
        .wrap(wrap), .load(load), .load_val(load_val), .min_val(min_val), .max_val(max_val),
        .clr_sticky(clr), .out(out1), .at_max(at_max1), .at_min(at_min1), .cfg_err(cfg_err1),
        .limit_pulse(pl1), .ovf_sticky(ov1), .unf_sticky(un1));

    typedef struct {
        bit rst, en, up, dn;
        int stp;
        bit wr, ld;
        int lv, mn, mx;
        bit clr;
        int e_out;
        bit e_pl, e_ov, e_un;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour, evaluated on the inputs present before the clock edge
    task automatic model_step(input int k);
        int o, s, mn, mx, lv;
        bit ue, de, so, su;
        o = m_out[k]; s = int'(step); mn = int'(min_val); mx = int'(max_val); lv = int'(load_val);
        so = 0; su = 0;
        if (reset) begin
            m_out[k] = rv[k]; m_pl[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_uq[k] = 0; m_dq[k] = 0;
            return;
        end
        ue = (k == 1) ? (up && !m_uq[k]) : up;
        de = (k == 1) ? (down && !m_dq[k]) : down;
        if (mn > mx) begin
            // configuration error: hold
        end else if (load) begin
            o = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
        end else if (!enable) begin
            // paused
        end else if (o < mn) begin
            o = mn;
        end else if (o > mx) begin
            o = mx;
        end else if ((ue != de) && s != 0) begin
            if (ue) begin
                if (o + s <= mx) o = o + s;
                else begin o = wrap ? mn : mx; so = 1; end
            end else begin
                if (o - s >= mn) o = o - s;
                else begin o = wrap ? mx : mn; su = 1; end
            end
        end
        m_out[k] = o;
        m_pl[k]  = so || su;
        m_ov[k]  = so || (m_ov[k] && !clr);
        m_un[k]  = su || (m_un[k] && !clr);
        m_uq[k]  = up;
        m_dq[k]  = down;
    endtask

    task automatic compare();
        int ce;
        ce = (int'(min_val) > int'(max_val)) ? 1 : 0;
        chk("m_out0", int'(out0), m_out[0]);
        chk("m_pulse0", int'(pl0), int'(m_pl[0]));
        chk("m_ovf0", int'(ov0), int'(m_ov[0]));
        chk("m_unf0", int'(un0), int'(m_un[0]));
        chk("m_atmax0", int'(at_max0), (m_out[0] == int'(max_val)) ? 1 : 0);
        chk("m_atmin0", int'(at_min0), (m_out[0] == int'(min_val)) ? 1 : 0);
        chk("m_cfg0", int'(cfg_err0), ce);
        chk("m_out1", int'(out1), m_out[1]);
        chk("m_pulse1", int'(pl1), int'(m_pl[1]));
        chk("m_ovf1", int'(ov1), int'(m_ov[1]));
        chk("m_unf1", int'(un1), int'(m_un[1]));
        chk("m_atmax1", int'(at_max1), (m_out[1] == int'(max_val)) ? 1 : 0);
        chk("m_atmin1", int'(at_min1), (m_out[1] == int'(min_val)) ? 1 : 0);
        chk("m_cfg1", int'(cfg_err1), ce);
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        reset = 0; enable = 1; up = 0; down = 0; step = 4'd1; wrap = 0;
        load = 0; load_val = 8'd0; clr = 0;
    endtask

    initial begin
        reset = 1; enable = 0; up = 0; down = 0; step = 4'd0; wrap = 0; load = 0;
        load_val = 8'd0; min_val = 8'd0; max_val = 8'd255; clr = 0;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_pl[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_uq[k] = 0; m_dq[k] = 0;
        end
        #2;

        //              rst en up dn stp wr ld lv   mn  mx  clr  out pl ov un
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   10, 100, 0,  0,   0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0,   10, 100, 0,  10,  0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 7, 1, 1, 95,  10, 100, 0,  95,  0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 7, 1, 0, 0,   10, 100, 0,  10,  1, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, 7, 1, 0, 0,   10, 100, 0,  100, 1, 1, 1};
        tbl[5]  = '{0, 1, 0, 0, 7, 1, 0, 0,   10, 100, 1,  100, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 7, 0, 0, 0,   10, 100, 0,  93,  0, 0, 0};
        tbl[7]  = '{0, 1, 1, 1, 7, 0, 0, 0,   10, 100, 0,  93,  0, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 0, 0,   10, 100, 0,  93,  0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 7, 0, 0, 0,   10, 100, 0,  93,  0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 1, 200, 20, 50,  0,  50,  0, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 1, 0, 0, 0,   60, 80,  0,  60,  0, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 1, 0, 0, 0,   60, 80,  0,  61,  0, 0, 0};
        tbl[13] = '{0, 1, 1, 0, 1, 0, 1, 0,   9,  3,   0,  61,  0, 0, 0};
        tbl[14] = '{0, 1, 1, 0, 1, 0, 0, 0,   60, 61,  1,  61,  1, 1, 0};
        tbl[15] = '{1, 1, 1, 0, 1, 0, 1, 77,  60, 61,  0,  0,   0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; up = tbl[i].up; down = tbl[i].dn;
            step = 4'(tbl[i].stp); wrap = tbl[i].wr; load = tbl[i].ld;
            load_val = 8'(tbl[i].lv); min_val = 8'(tbl[i].mn); max_val = 8'(tbl[i].mx);
            clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_out", i), int'(out0), tbl[i].e_out);
            chk($sformatf("tbl%0d_pulse", i), int'(pl0), int'(tbl[i].e_pl));
            chk($sformatf("tbl%0d_ovf", i), int'(ov0), int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_unf", i), int'(un0), int'(tbl[i].e_un));
        end

        // Plain 4-bit saturating counter behaviour
        reset = 1; tick();
        idle_inputs(); min_val = 8'd0; max_val = 8'd15; up = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("leg_up_out", int'(out0), (i < 15) ? i + 1 : 15);
            chk("leg_up_ovf", int'(ov0), (i >= 15) ? 1 : 0);
        end
        chk("leg_at_max", int'(at_max0), 1);
        up = 0; down = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("leg_dn_out", int'(out0), (i < 15) ? 14 - i : 0);
            chk("leg_dn_unf", int'(un0), (i >= 15) ? 1 : 0);
        end
        chk("leg_at_min", int'(at_min0), 1);

        // Edge-mode sequences on the second instance
        reset = 1; tick();
        chk("edge_reset_val", int'(out1), 200);
        idle_inputs(); min_val = 8'd0; max_val = 8'd255; tick();
        load = 1; load_val = 8'd50; tick();
        load = 0; up = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("edge_held_up", int'(out1), 51);
        up = 0; tick();
        up = 1; down = 1; tick();
        chk("edge_both_rise", int'(out1), 51);
        up = 0; down = 0; tick();
        enable = 0; up = 1;
        for (int i = 0; i < 3; i++) tick();
        enable = 1;
        for (int i = 0; i < 2; i++) tick();
        chk("edge_paused_rise", int'(out1), 51);

        // Randomised traffic against the model
        idle_inputs(); min_val = 8'd20; max_val = 8'd60;
        for (int n = 0; n < 3000; n++) begin
            int mn, mx, t;
            reset    = ($urandom % 64) == 0;
            enable   = ($urandom % 8) != 0;
            up       = 1'($urandom % 2);
            down     = ($urandom % 3) == 0;
            step     = (($urandom % 6) == 0) ? 4'd0 : 4'($urandom % 16);
            wrap     = 1'($urandom % 2);
            load     = ($urandom % 20) == 0;
            load_val = 8'($urandom % 256);
            clr      = ($urandom % 16) == 0;
            if (($urandom % 40) == 0) begin
                mn = int'($urandom % 256);
                mx = mn + int'($urandom % 60);
                if (mx > 255) mx = 255;
                if (($urandom % 8) == 0 && mn != mx) begin
                    t = mn; mn = mx; mx = t;
                end
                min_val = 8'(mn); max_val = 8'(mx);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down event counter with programmable limits, selectable saturate/wrap behaviour, variable step, synchronous load and limit-event flags. It is the general-purpose counting block for occupancy and position tracking. With WIDTH=4, limits 0..15, step 1, saturate mode and level mode, it behaves as a plain 4-bit saturating up/down counter.

## Interface
Parameters:
- WIDTH, 8, counter width in bits
- STEP_W, 4, width of the step input
- EDGE_MODE, 0, 0 = count every enabled cycle while a request is held; 1 = count once per rising edge of a request
- RESET_VAL, 0, value loaded into out on reset

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  1 = counting/clamping allowed; 0 = paused (load still honoured)
- up  in  1  count-up request
- down  in  1  count-down request
- step  in  STEP_W  increment/decrement amount, unsigned
- wrap  in  1  0 = saturate at limits, 1 = wrap to opposite limit
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- min_val  in  WIDTH  lower limit, inclusive, unsigned
- max_val  in  WIDTH  upper limit, inclusive, unsigned
- clr_sticky  in  1  clears ovf_sticky/unf_sticky
- out  out  WIDTH  registered count
- at_max  out  1  combinational, out == max_val
- at_min  out  1  combinational, out == min_val
- cfg_err  out  1  combinational, min_val > max_val
- limit_pulse  out  1  registered, one-cycle pulse after a clipped or wrapped count
- ovf_sticky  out  1  registered, an up count hit the upper limit
- unf_sticky  out  1  registered, a down count hit the lower limit

## Operation
- Priority each cycle: reset > cfg_err hold > load > enable gate > range clamp > count.
- reset: out=RESET_VAL; limit_pulse, ovf_sticky, unf_sticky and the edge registers up_q/down_q = 0.
- cfg_err=1: out holds and no flags are set. load is ignored. Edge registers still update.
- load=1: out = load_val clamped into [min_val, max_val]. Load works regardless of enable and does not count in that cycle.
- Request decode:
  - Level mode: up_ev = up, dn_ev = down.
  - Edge mode: up_ev = up & ~up_q, dn_ev = down & ~down_q. up_q/down_q sample every cycle, even when paused or loading.
  - If up_ev and dn_ev are both set, or step=0, there is no count and no flags.
- Range clamp: if enable=1 and out is outside [min_val, max_val] (for example after limits change or after reset), out becomes the nearest limit. No count happens that cycle, any event in that cycle is dropped, and no flags are set.
- Up count: sum = out + step, computed at WIDTH+1 bits.
  - sum ≤ max_val: out = sum.
  - Otherwise saturate mode gives out = max_val, and wrap mode gives out = min_val. Any excess is discarded.
  - A clipped/wrapped up count sets ovf_sticky and pulses limit_pulse. An up count from out == max_val also counts as clipped.
- Down count: if out ≥ min_val + step (computed at WIDTH+1 bits), out = out − step.
  - Otherwise saturate mode gives out = min_val, and wrap mode gives out = max_val.
  - This sets unf_sticky and pulses limit_pulse.
- enable=0: out holds and no clamp is applied. Requests are dropped, not queued.
- Sticky flags:
  - clr_sticky clears them.
  - If a set and clr_sticky occur in the same cycle, the set wins.

## Timing
- out, limit_pulse and the sticky flags update one cycle after the qualifying input edge (latency 1).
- at_max, at_min and cfg_err follow out and the limits combinationally in the same cycle.
- limit_pulse is high for exactly one cycle per clipped/wrapped count. In level mode it is high on every cycle a request is held at a saturated limit.
- Edge mode adds no latency: a rising edge sampled at cycle n updates out at the n+1 edge.
- Reset asserted mid-count overrides everything. Counting resumes on the first cycle after reset deasserts.

## Test plan
- Legacy equivalence (WIDTH=4, limits 0..15, step 1, saturate, level): hold up for 20 cycles → out goes 0..15 and stays at 15; ovf_sticky=1 from cycle 16; at_max=1. Then hold down 20 cycles → out reaches 0; unf_sticky=1.
- Wrap with step (WIDTH=8, limits 10..100, step 7, wrap): load 95, up 1 cycle → out=10, limit_pulse for 1 cycle. Then down 1 cycle → out=100.
- Edge mode: hold up high for 10 cycles → out increments by exactly 1. up and down rising together → no change. up held while enable=0, then enable=1 → no count.
- Load and clamp: limits 20..50, load_val=200 → out=50. Then change min to 60 and max to 80 with enable=1 → out=60 next cycle, with no flag set.
- cfg_err: min=9, max=3 → cfg_err=1. Requests and load are ignored and out holds.
- Priority: clr_sticky together with a clipped up → ovf_sticky stays 1. Reset together with load and up → out=RESET_VAL and all flags 0.
